prc_lcd_copier: RTL and testbench

- Frame-copy engine that sits directly upstream of the LCD controller.
- On a start pulse it reads the 96x64 1bpp framebuffer from system RAM and streams it into the LCD controller's command (0x20FE) and data (0x20FF) ports as ordinary bus writes.
- It owns the bus only after an explicit request/grant handshake with the CPU arbiter.

---
 rtl/prc_pkg.sv | 26 ++
 rtl/prc_lcd_copier_if.sv | 24 ++
 rtl/prc_lcd_copier.sv | 166 ++++++++++++++++
 tb/tb_prc_lcd_copier.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prc_pkg.sv
// Shared types and constants for the LCD frame-copy engine.
package prc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    CMD_WR,
    CMD_GAP,
    FETCH,
    LATCH,
    DAT_WR,
    DAT_GAP,
    FIN
  } copier_state_e;

  // LCD controller port addresses and the opcodes used to position it
  localparam logic [23:0] LCD_CMD_ADDR  = 24'h0020FE;
  localparam logic [23:0] LCD_DATA_ADDR = 24'h0020FF;

  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  localparam logic [23:0] DEFAULT_FB_BASE = 24'h001000;

endpackage

// File: rtl/prc_lcd_copier_if.sv
// Bus-side signals of the frame copier: arbiter handshake, framebuffer read
// port and LCD write port.
interface prc_lcd_copier_if;

  logic        bus_request;
  logic        bus_grant;
  logic [23:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data_in;
  logic [23:0] bus_address;
  logic [7:0]  bus_data;
  logic        bus_write;

  modport master (
    output bus_request, mem_address, mem_read, bus_address, bus_data, bus_write,
    input  bus_grant, mem_data_in
  );

  modport slave (
    input  bus_request, mem_address, mem_read, bus_address, bus_data, bus_write,
    output bus_grant, mem_data_in
  );

endinterface

// File: rtl/prc_lcd_copier.sv
// Copies the 1bpp framebuffer into the LCD controller as bus writes.
// Build option: define PRC_COPY_PREFETCH_EN to overlap the next byte read with each data gap.
module prc_lcd_copier
  import prc_pkg::*;
#(
  parameter logic [23:0] FB_BASE = DEFAULT_FB_BASE,
  parameter int unsigned COLUMNS = 96,
  parameter int unsigned PAGES   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  prc_lcd_copier_if.master bus
);

  localparam int unsigned COL_W  = $clog2(COLUMNS);
  localparam int unsigned PAGE_W = $clog2(PAGES);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLUMNS - 1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES - 1);

  copier_state_e     state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        cmd_idx_q, cmd_idx_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        cmd_byte;

  // Offset is formed at 11 bits and zero-extended before the base is added.
  function automatic logic [23:0] fb_addr(input logic [PAGE_W-1:0] p,
                                          input logic [COL_W-1:0]  c);
    logic [10:0] offset;
    offset = 11'(p) * 11'(COLUMNS) + 11'(c);
    return FB_BASE + {13'd0, offset};
  endfunction

  always_comb begin
    unique case (cmd_idx_q)
      2'd0:    cmd_byte = CMD_SET_PAGE | 8'(page_q);
      2'd1:    cmd_byte = CMD_COL_LO;
      default: cmd_byte = CMD_COL_HI;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    page_d          = page_q;
    col_d           = col_q;
    cmd_idx_d       = cmd_idx_q;
    data_d          = data_q;
    busy            = (state_q != IDLE) && (state_q != FIN);
    done            = 1'b0;
    bus.bus_request = (state_q != IDLE) && (state_q != FIN);
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    bus.bus_address = '0;
    bus.bus_data    = '0;
    bus.bus_write   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ;
          page_d    = '0;
          col_d     = '0;
          cmd_idx_d = '0;
        end
      end
      REQ: begin
        if (bus.bus_grant) begin
          state_d   = CMD_WR;
          cmd_idx_d = '0;
        end
      end
      CMD_WR: begin
        bus.bus_address = LCD_CMD_ADDR;
        bus.bus_data    = cmd_byte;
        if (bus.bus_grant) begin
          bus.bus_write = 1'b1;
          state_d       = CMD_GAP;
        end
      end
      // The LCD latches on the bus_write edge, so every write is followed by
      // a low cycle with address and data held.
      CMD_GAP: begin
        bus.bus_address = LCD_CMD_ADDR;
        bus.bus_data    = cmd_byte;
        if (cmd_idx_q == 2'd2) begin
          state_d = FETCH;
          col_d   = '0;
        end else begin
          cmd_idx_d = cmd_idx_q + 2'd1;
          state_d   = CMD_WR;
        end
      end
      FETCH: begin
        if (bus.bus_grant) begin
          bus.mem_read    = 1'b1;
          bus.mem_address = fb_addr(page_q, col_q);
          state_d         = LATCH;
        end
      end
      LATCH: begin
        data_d  = bus.mem_data_in;
        state_d = DAT_WR;
      end
      DAT_WR: begin
        bus.bus_address = LCD_DATA_ADDR;
        bus.bus_data    = data_q;
        if (bus.bus_grant) begin
          bus.bus_write = 1'b1;
          state_d       = DAT_GAP;
        end
      end
      DAT_GAP: begin
        bus.bus_address = LCD_DATA_ADDR;
        bus.bus_data    = data_q;
        if (col_q != LAST_COL) begin
          col_d = col_q + COL_W'(1);
`ifdef PRC_COPY_PREFETCH_EN
          // Without grant the prefetch is skipped and FETCH issues the read.
          if (bus.bus_grant) begin
            bus.mem_read    = 1'b1;
            bus.mem_address = fb_addr(page_q, col_q + COL_W'(1));
            state_d         = LATCH;
          end else begin
            state_d = FETCH;
          end
`else
          state_d = FETCH;
`endif
        end else if (page_q != LAST_PAGE) begin
          page_d    = page_q + PAGE_W'(1);
          cmd_idx_d = '0;
          state_d   = CMD_WR;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      page_q    <= '0;
      col_q     <= '0;
      cmd_idx_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      col_q     <= col_d;
      cmd_idx_q <= cmd_idx_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_prc_lcd_copier.sv
// Directed bench for prc_lcd_copier: write-log scoreboard, LCD RAM model and
// cycle-accurate completion timing.
module tb_prc_lcd_copier;

`ifdef PRC_COPY_PREFETCH_EN
  localparam int LAT = 2361;
`else
  localparam int LAT = 3121;
`endif
  localparam int NWR = 792;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  prc_lcd_copier_if bus_if ();

  prc_lcd_copier dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  int wr_count = 0;
  logic        prev_write = 1'b0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_ad = '0;
  logic [31:0] exp_q[$];

  logic [7:0] lcd_ram [0:8][0:131];
  logic [3:0] lcd_page = '0;
  logic [7:0] lcd_col = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({24'h0020FE, 8'hB0 | 8'(p)});
      exp_q.push_back({24'h0020FE, 8'h00});
      exp_q.push_back({24'h0020FE, 8'h10});
      for (int c = 0; c < 96; c++)
        exp_q.push_back({24'h0020FF, 8'((p * 96 + c) & 255)});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n0;
    n0 = done_count;
    for (int i = 0; i < 6000 && done_count == n0; i++) tick();
    check({tag, "_done"}, 64'(done_count), 64'(n0 + 1));
    check({tag, "_latency"}, 64'(done_cyc - busy_cyc), 64'(exp_lat));
  endtask

  // Framebuffer model: one-cycle read latency, byte value = offset & 0xFF.
  always @(posedge clk)
    if (bus_if.mem_read) bus_if.mem_data_in <= 8'(bus_if.mem_address - 24'h001000);

  // Bus monitor, LCD model and scoreboard pop.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_write = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (busy && !prev_busy) busy_cyc = cyc;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("done_without_busy", 64'(busy), 64'(0));
      end
      if (bus_if.bus_write) begin
        wr_count++;
        check("write_width", 64'(prev_write), 64'(0));
        if (bus_if.bus_address == 24'h0020FE) begin
          if (bus_if.bus_data[7:4] == 4'hB) lcd_page = bus_if.bus_data[3:0];
          else if (bus_if.bus_data[7:4] == 4'h1) lcd_col[7:4] = bus_if.bus_data[3:0];
          else lcd_col[3:0] = bus_if.bus_data[3:0];
        end else if (bus_if.bus_address == 24'h0020FF) begin
          if (lcd_col < 8'd132 && lcd_page < 4'd9) lcd_ram[lcd_page][lcd_col] = bus_if.bus_data;
          lcd_col = lcd_col + 8'd1;
        end
        check("write_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
          check("write_value", 64'({bus_if.bus_address, bus_if.bus_data}), 64'(exp_q.pop_front()));
      end else if (prev_write) begin
        check("gap_hold", 64'({bus_if.bus_address, bus_if.bus_data}), 64'(prev_ad));
      end
      if (!bus_if.bus_grant)
        check("strobe_without_grant", 64'({bus_if.bus_write, bus_if.mem_read}), 64'(0));
      if (bus_if.mem_read)
        check("read_range", 64'(bus_if.mem_address >= 24'h001000 && bus_if.mem_address <= 24'h0012FF), 64'(1));
      prev_write = bus_if.bus_write;
      prev_ad    = {bus_if.bus_address, bus_if.bus_data};
      prev_busy  = busy;
    end
  end

  initial begin
    int found;
    int n0;
    reset = 1'b1;
    start = 1'b0;
    bus_if.bus_grant = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 64'({busy, done, bus_if.bus_request, bus_if.mem_read, bus_if.mem_address,
                                bus_if.bus_address, bus_if.bus_data, bus_if.bus_write}), 64'(0));
    reset = 1'b0;
    tick();

    // 1: plain copy, grant held high
    wr_count = 0;
    push_expected();
    pulse_start();
    check("s1_busy_request", 64'({busy, bus_if.bus_request}), 64'(2'b11));
    wait_done("s1", LAT);
    check("s1_writes", 64'(wr_count), 64'(NWR));
    check("s1_queue_empty", 64'(exp_q.size()), 64'(0));
    tick();
    check("s1_idle_after_fin", 64'({busy, done, bus_if.bus_request}), 64'(0));

    // 3: grant withdrawn for 10 cycles just before page 3 column 40 is written
    repeat (3) tick();
    wr_count = 0;
    push_expected();
    pulse_start();
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      tick();
      if (bus_if.mem_read && bus_if.mem_address == 24'h001000 + 24'(3 * 96 + 40)) found = 1;
    end
    check("s3_target_read", 64'(found), 64'(1));
    tick();
    tick();
    bus_if.bus_grant = 1'b0;
    repeat (10) tick();
    bus_if.bus_grant = 1'b1;
    wait_done("s3", LAT + 10);
    check("s3_writes", 64'(wr_count), 64'(NWR));
    check("s3_queue_empty", 64'(exp_q.size()), 64'(0));

    // 4: second start during a copy is ignored
    repeat (3) tick();
    wr_count = 0;
    push_expected();
    n0 = done_count;
    pulse_start();
    repeat (500) tick();
    pulse_start();
    wait_done("s4", LAT);
    repeat (20) tick();
    check("s4_single_done", 64'(done_count), 64'(n0 + 1));
    check("s4_not_restarted", 64'(busy), 64'(0));
    check("s4_writes", 64'(wr_count), 64'(NWR));
    check("s4_queue_empty", 64'(exp_q.size()), 64'(0));

    // 5: reset in the middle of a copy, then a fresh full copy
    wr_count = 0;
    push_expected();
    n0 = done_count;
    pulse_start();
    repeat (1000) tick();
    reset = 1'b1;
    tick();
    check("s5_reset_outputs", 64'({busy, done, bus_if.bus_request, bus_if.mem_read, bus_if.mem_address,
                                   bus_if.bus_address, bus_if.bus_data, bus_if.bus_write}), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    check("s5_no_done", 64'(done_count), 64'(n0));
    check("s5_idle", 64'(busy), 64'(0));
    wr_count = 0;
    push_expected();
    pulse_start();
    wait_done("s5", LAT);
    check("s5_writes", 64'(wr_count), 64'(NWR));
    check("s5_queue_empty", 64'(exp_q.size()), 64'(0));

    // LCD RAM image must match the framebuffer
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 96; c++)
        check("lcd_ram", 64'(lcd_ram[p][c]), 64'((p * 96 + c) & 255));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
